decode_issue: RTL and testbench
===============================

# decode_issue

Decode-and-issue stage sitting directly downstream of instruction fetch. Accepts one `{pc, command}` pair per handshake and decodes it into register addresses, an extended immediate and control flags. Holds the instruction in a single-entry register until its source and destination registers are free according to an internal 32-entry scoreboard. Issues to execute with a valid/ready handshake and back-pressures fetch with `stall`.

## Interface
- `REG_BITS`, 5 — register address width; the scoreboard has 2^REG_BITS entries.
- `clk  in  1` — sole clock; all state updates on posedge.
- `rst  in  1` — synchronous, active-high reset.
- `in_valid  in  1` — `pc`/`command` valid this cycle.
- `pc  in  32` — address of `command`.
- `command  in  32` — instruction word.
- `stall  out  1` — combinational; high when the stage cannot accept an instruction this cycle.
- `flush  in  1` — discard the held instruction (branch redirect).
- `out_valid  out  1` — decoded instruction presented, hazard-free.
- `out_ready  in  1` — execute accepts; `fire = out_valid & out_ready`.
- `out_pc  out  32`
- `rs_addr`, `rt_addr`  out  REG_BITS — source register addresses.
- `wb_addr  out  REG_BITS`, `wb_en  out  1` — destination register and write flag.
- `imm  out  32` — extended immediate or jump/branch target field.
- `opcode  out  6`, `funct  out  6` — raw fields.
- `mem_rd`, `mem_wr`, `is_branch`, `is_jump`, `illegal`  out  1 each.
- `wb_done  in  1`, `wb_done_addr  in  REG_BITS` — a write retired; clear that register's scoreboard bit.

## Operation
- FSM states:
  - EMPTY: no instruction held.
  - HOLD: an instruction is held.
- Accept condition: `in_valid & ~stall & ~flush`.
  - In EMPTY, accept → HOLD.
  - In HOLD with `fire`, accept → stays HOLD; otherwise, `fire` alone → EMPTY.
- `stall = HOLD & ~fire`. An `in_valid` while `stall` is high is ignored.
- Decode is registered on accept. Fields: `op=[31:26]`, `rs=[25:21]`, `rt=[20:16]`, `rd=[15:11]`, `funct=[5:0]`.
  - `000000` R-type: reads rs,rt; `wb_addr=rd`; `wb_en = (rd!=0)`. Word `0` is therefore a NOP.
  - `001001` ADDIU, `001010` SLTI: reads rs; `wb_addr=rt`; `imm` sign-extended.
  - `001101` ORI: reads rs; `wb_addr=rt`; `imm` zero-extended.
  - `001111` LUI: `wb_addr=rt`; `imm = {cmd[15:0],16'h0}`.
  - `100011` LW: reads rs; `wb_addr=rt`; `mem_rd=1`; `imm` sign-extended.
  - `101011` SW: reads rs,rt; `mem_wr=1`; `imm` sign-extended.
  - `000100` BEQ, `000101` BNE: reads rs,rt; `is_branch=1`; `imm` sign-extended.
  - `110010` BC: `is_branch=1`; `imm = {6'h0,cmd[25:0]}`.
  - `000010` J: `is_jump=1`; `imm = {6'h0,cmd[25:0]}`.
  - `000011` JAL: `is_jump=1`; `imm = {6'h0,cmd[25:0]}`; `wb_addr=31`; `wb_en=1`.
  - Any other opcode: `illegal=1`, all other flags 0, `wb_en=0`; issues as a NOP.
- Unused source fields force `rs_addr`/`rt_addr` to 0.
- Scoreboard `pending[2^REG_BITS]`:
  - Bit 0 is never set.
  - `fire & wb_en` sets `pending[wb_addr]`.
  - `wb_done` clears `pending[wb_done_addr]`.
  - Set and clear of the same bit in one cycle: the set wins.
- Hazard: any of `pending[rs_addr]`, `pending[rt_addr]`, or `pending[wb_addr]` (WAW, only when `wb_en`) is set.
- `out_valid = HOLD & ~hazard`.
- `flush` → EMPTY. Same-cycle `fire` is suppressed, so no scoreboard set occurs. Same-cycle `in_valid` is dropped. The scoreboard is kept, because in-flight writes still retire.

## Timing
- Reset: state EMPTY, `pending` all 0, every output 0 (`out_valid=0`, `stall=0`, `out_pc=0`, `imm=0`, all flags 0).
- Latency: accept at cycle t → `out_valid` at t+1 if hazard-free.
- Throughput: one instruction per cycle with `out_ready` held high and no hazards.
- Outputs are stable while `out_valid & ~out_ready`.
- A hazard clears one cycle after the `wb_done` that resolves it (zero cycles with the bypass, see Configuration).
- `rst` mid-HOLD discards the held instruction and all pending bits.

## Configuration
- `DECODE_WB_BYPASS_EN` defined: the hazard check uses `pending & ~(wb_done ? onehot(wb_done_addr) : 0)`. A retiring write unblocks the held instruction in the same cycle.
- Undefined: the hazard check uses registered `pending` only (one extra cycle, shorter combinational path).

## Test plan
- Reset, then `command=32'h0`, `pc=0` → `out_valid=1` at the next cycle, `wb_en=0`, `illegal=0`.
- ADDIU `32'h2402FFFF` (rt=2, imm=-1) → `imm=32'hFFFFFFFF`, `wb_addr=2`, `wb_en=1`. After `fire`, `pending[2]=1`.
- Then ADDU `rd=3, rs=2, rt=0` → `out_valid=0` and `stall=1` until `wb_done`/addr=2. `out_valid` rises next cycle without the macro, same cycle with it.
- `out_ready=0` for 3 cycles with a held instruction → outputs unchanged, `stall=1`, and a second `in_valid` is not captured.
- `flush` coincident with `fire` and `in_valid` → state EMPTY, no pending bit set, next cycle `out_valid=0`.
- Same-cycle `fire` of LW rt=5 and `wb_done` addr=5 → `pending[5]=1` afterwards.

Source files
------------

// File: rtl/decode_issue.sv
// Decode-and-issue stage: single-entry holding register, 2^REG_BITS-entry write scoreboard.
// Optional DECODE_WB_BYPASS_EN lets a retiring write unblock the held instruction same-cycle.
module decode_issue #(
   parameter int unsigned REG_BITS = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic [31:0]         pc,
   input  logic [31:0]         command,
   output logic                stall,
   input  logic                flush,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [31:0]         out_pc,
   output logic [REG_BITS-1:0] rs_addr,
   output logic [REG_BITS-1:0] rt_addr,
   output logic [REG_BITS-1:0] wb_addr,
   output logic                wb_en,
   output logic [31:0]         imm,
   output logic [5:0]          opcode,
   output logic [5:0]          funct,
   output logic                mem_rd,
   output logic                mem_wr,
   output logic                is_branch,
   output logic                is_jump,
   output logic                illegal,
   input  logic                wb_done,
   input  logic [REG_BITS-1:0] wb_done_addr
);

   localparam int unsigned NumRegs = 2 ** REG_BITS;

   typedef enum logic [0:0] {StEmpty, StHold} state_e;

   state_e               state_q, state_d;
   logic [NumRegs-1:0]   pending_q, pending_d, pending_eff;
   logic                 hold, hazard, fire, accept;

   logic [REG_BITS-1:0]  dec_rs, dec_rt, dec_wb;
   logic                 dec_wb_en, dec_mem_rd, dec_mem_wr, dec_branch, dec_jump, dec_illegal;
   logic [31:0]          dec_imm, sext, jtgt;

   assign sext = {{16{command[15]}}, command[15:0]};
   assign jtgt = {6'h0, command[25:0]};

   always_comb begin
      dec_rs      = '0;
      dec_rt      = '0;
      dec_wb      = '0;
      dec_wb_en   = 1'b0;
      dec_imm     = '0;
      dec_mem_rd  = 1'b0;
      dec_mem_wr  = 1'b0;
      dec_branch  = 1'b0;
      dec_jump    = 1'b0;
      dec_illegal = 1'b0;
      unique case (command[31:26])
         6'b000000: begin
            dec_rs    = REG_BITS'(command[25:21]);
            dec_rt    = REG_BITS'(command[20:16]);
            dec_wb    = REG_BITS'(command[15:11]);
            dec_wb_en = (command[15:11] != 5'd0);
         end
         6'b001001, 6'b001010, 6'b001101, 6'b100011: begin
            dec_rs     = REG_BITS'(command[25:21]);
            dec_wb     = REG_BITS'(command[20:16]);
            dec_wb_en  = 1'b1;
            dec_imm    = (command[31:26] == 6'b001101) ? {16'h0, command[15:0]} : sext;
            dec_mem_rd = (command[31:26] == 6'b100011);
         end
         6'b001111: begin
            dec_wb    = REG_BITS'(command[20:16]);
            dec_wb_en = 1'b1;
            dec_imm   = {command[15:0], 16'h0};
         end
         6'b101011, 6'b000100, 6'b000101: begin
            dec_rs     = REG_BITS'(command[25:21]);
            dec_rt     = REG_BITS'(command[20:16]);
            dec_imm    = sext;
            dec_mem_wr = (command[31:26] == 6'b101011);
            dec_branch = (command[31:26] != 6'b101011);
         end
         6'b110010: begin
            dec_branch = 1'b1;
            dec_imm    = jtgt;
         end
         6'b000010: begin
            dec_jump = 1'b1;
            dec_imm  = jtgt;
         end
         6'b000011: begin
            dec_jump  = 1'b1;
            dec_imm   = jtgt;
            dec_wb    = REG_BITS'(31);
            dec_wb_en = 1'b1;
         end
         default: dec_illegal = 1'b1;
      endcase
   end

`ifdef DECODE_WB_BYPASS_EN
   assign pending_eff = pending_q & ~(wb_done ? (NumRegs'(1) << wb_done_addr) : '0);
`else
   assign pending_eff = pending_q;
`endif

   assign hold      = (state_q == StHold);
   assign hazard    = pending_eff[rs_addr] | pending_eff[rt_addr] | (wb_en & pending_eff[wb_addr]);
   assign out_valid = hold & ~hazard;
   assign stall     = hold & ~(out_valid & out_ready);
   // A flush kills the issue, so the scoreboard never sees the discarded instruction.
   assign fire      = out_valid & out_ready & ~flush;
   assign accept    = in_valid & ~stall & ~flush;

   always_comb begin
      state_d = state_q;
      if (flush)       state_d = StEmpty;
      else if (accept) state_d = StHold;
      else if (fire)   state_d = StEmpty;
   end

   // Clear first so a same-cycle set of the same register wins.
   always_comb begin
      pending_d = pending_q;
      if (wb_done)       pending_d[wb_done_addr] = 1'b0;
      if (fire && wb_en) pending_d[wb_addr] = 1'b1;
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StEmpty;
         pending_q <= '0;
         out_pc    <= '0;
         rs_addr   <= '0;
         rt_addr   <= '0;
         wb_addr   <= '0;
         wb_en     <= 1'b0;
         imm       <= '0;
         opcode    <= '0;
         funct     <= '0;
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
         is_branch <= 1'b0;
         is_jump   <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         if (accept) begin
            out_pc    <= pc;
            rs_addr   <= dec_rs;
            rt_addr   <= dec_rt;
            wb_addr   <= dec_wb;
            wb_en     <= dec_wb_en;
            imm       <= dec_imm;
            opcode    <= command[31:26];
            funct     <= command[5:0];
            mem_rd    <= dec_mem_rd;
            mem_wr    <= dec_mem_wr;
            is_branch <= dec_branch;
            is_jump   <= dec_jump;
            illegal   <= dec_illegal;
         end
      end
   end

endmodule

// File: tb/tb_decode_issue.sv
// Directed self-checking bench for decode_issue: decode table plus handshake/scoreboard sequences.
module tb_decode_issue;

   logic        clk = 1'b0;
   logic        rst, in_valid, flush, out_ready, wb_done;
   logic [31:0] pc, command;
   logic        stall, out_valid, wb_en, mem_rd, mem_wr, is_branch, is_jump, illegal;
   logic [31:0] out_pc, imm;
   logic [4:0]  rs_addr, rt_addr, wb_addr, wb_done_addr;
   logic [5:0]  opcode, funct;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   decode_issue #(.REG_BITS(5)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .pc(pc), .command(command), .stall(stall),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .wb_addr(wb_addr), .wb_en(wb_en), .imm(imm),
      .opcode(opcode), .funct(funct), .mem_rd(mem_rd), .mem_wr(mem_wr), .is_branch(is_branch),
      .is_jump(is_jump), .illegal(illegal), .wb_done(wb_done), .wb_done_addr(wb_done_addr)
   );

   typedef struct {
      logic [31:0] cmd;
      logic [31:0] pc;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  wb;
      logic        wben;
      logic [31:0] imm;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [4:0]  flg;  // {mem_rd, mem_wr, is_branch, is_jump, illegal}
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic load(input logic [31:0] c, input logic [31:0] p);
      in_valid = 1'b1;
      command  = c;
      pc       = p;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic retire(input logic [4:0] a);
      wb_done      = 1'b1;
      wb_done_addr = a;
      tick();
      wb_done      = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; wb_done = 1'b0;
      pc = '0; command = '0; wb_done_addr = '0;

      vecs[0]  = '{32'h00000000, 32'h1000, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0,        6'h00, 6'h00, 5'b00000};
      vecs[1]  = '{32'h2402FFFF, 32'h1004, 5'd0, 5'd0, 5'd2, 1'b1, 32'hFFFFFFFF, 6'h09, 6'h3F, 5'b00000};
      vecs[2]  = '{32'h00401821, 32'h1008, 5'd2, 5'd0, 5'd3, 1'b1, 32'h0,        6'h00, 6'h21, 5'b00000};
      vecs[3]  = '{32'h34248001, 32'h100C, 5'd1, 5'd0, 5'd4, 1'b1, 32'h00008001, 6'h0D, 6'h01, 5'b00000};
      vecs[4]  = '{32'h3C071234, 32'h1010, 5'd0, 5'd0, 5'd7, 1'b1, 32'h12340000, 6'h0F, 6'h34, 5'b00000};
      vecs[5]  = '{32'h8C65FFF0, 32'h1014, 5'd3, 5'd0, 5'd5, 1'b1, 32'hFFFFFFF0, 6'h23, 6'h30, 5'b10000};
      vecs[6]  = '{32'hACC80010, 32'h1018, 5'd6, 5'd8, 5'd0, 1'b0, 32'h00000010, 6'h2B, 6'h10, 5'b01000};
      vecs[7]  = '{32'h10228000, 32'h101C, 5'd1, 5'd2, 5'd0, 1'b0, 32'hFFFF8000, 6'h04, 6'h00, 5'b00100};
      vecs[8]  = '{32'hCBFFFFFF, 32'h1020, 5'd0, 5'd0, 5'd0, 1'b0, 32'h03FFFFFF, 6'h32, 6'h3F, 5'b00100};
      vecs[9]  = '{32'h08123456, 32'h1024, 5'd0, 5'd0, 5'd0, 1'b0, 32'h00123456, 6'h02, 6'h16, 5'b00010};
      vecs[10] = '{32'h0C000010, 32'h1028, 5'd0, 5'd0, 5'd31, 1'b1, 32'h00000010, 6'h03, 6'h10, 5'b00010};
      vecs[11] = '{32'hFFFFFFFF, 32'h102C, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0,        6'h3F, 6'h3F, 5'b00001};
      vecs[12] = '{32'h00220020, 32'h1030, 5'd1, 5'd2, 5'd0, 1'b0, 32'h0,        6'h00, 6'h20, 5'b00000};
      vecs[13] = '{32'h292A7FFF, 32'h1034, 5'd9, 5'd0, 5'd10, 1'b1, 32'h00007FFF, 6'h0A, 6'h3F, 5'b00000};
      vecs[14] = '{32'h14800001, 32'h1038, 5'd4, 5'd0, 5'd0, 1'b0, 32'h00000001, 6'h05, 6'h01, 5'b00100};

      tick(); tick();
      rst = 1'b0;
      tick();
      chk("reset out_valid", {31'b0, out_valid}, 32'd0);
      chk("reset stall", {31'b0, stall}, 32'd0);
      chk("reset out_pc", out_pc, 32'd0);
      chk("reset imm", imm, 32'd0);
      chk("reset flags", {26'b0, wb_en, mem_rd, mem_wr, is_branch, is_jump, illegal}, 32'd0);

      // Decode table: load, inspect while held, flush away so the scoreboard stays clean.
      for (int i = 0; i < 15; i++) begin
         load(vecs[i].cmd, vecs[i].pc);
         chk($sformatf("v%0d out_valid", i), {31'b0, out_valid}, 32'd1);
         chk($sformatf("v%0d out_pc", i), out_pc, vecs[i].pc);
         chk($sformatf("v%0d rs_addr", i), {27'b0, rs_addr}, {27'b0, vecs[i].rs});
         chk($sformatf("v%0d rt_addr", i), {27'b0, rt_addr}, {27'b0, vecs[i].rt});
         chk($sformatf("v%0d wb_addr", i), {27'b0, wb_addr}, {27'b0, vecs[i].wb});
         chk($sformatf("v%0d wb_en", i), {31'b0, wb_en}, {31'b0, vecs[i].wben});
         chk($sformatf("v%0d imm", i), imm, vecs[i].imm);
         chk($sformatf("v%0d opcode", i), {26'b0, opcode}, {26'b0, vecs[i].op});
         chk($sformatf("v%0d funct", i), {26'b0, funct}, {26'b0, vecs[i].fn});
         chk($sformatf("v%0d flags", i), {27'b0, mem_rd, mem_wr, is_branch, is_jump, illegal},
             {27'b0, vecs[i].flg});
         flush = 1'b1;
         tick();
         flush = 1'b0;
         chk($sformatf("v%0d flushed", i), {31'b0, out_valid}, 32'd0);
      end

      // Back-to-back issue with out_ready held high.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      command   = 32'h0;
      for (int i = 0; i < 4; i++) begin
         pc = 32'h10 + 32'(4 * i);
         tick();
         chk($sformatf("tput%0d out_valid", i), {31'b0, out_valid}, 32'd1);
         chk($sformatf("tput%0d out_pc", i), out_pc, 32'h10 + 32'(4 * i));
         chk($sformatf("tput%0d stall", i), {31'b0, stall}, 32'd0);
      end
      in_valid = 1'b0;
      tick();
      out_ready = 1'b0;
      chk("tput drained", {31'b0, out_valid}, 32'd0);

      // ADDIU r2 issues, then ADDU reading r2 waits for its retirement.
      load(32'h2402FFFF, 32'h100);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("addiu issued", {31'b0, stall}, 32'd0);
      load(32'h00401821, 32'h104);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("raw%0d out_valid", i), {31'b0, out_valid}, 32'd0);
         chk($sformatf("raw%0d stall", i), {31'b0, stall}, 32'd1);
         tick();
      end
      out_ready    = 1'b0;
      wb_done      = 1'b1;
      wb_done_addr = 5'd2;
      #1;
`ifdef DECODE_WB_BYPASS_EN
      chk("raw bypass out_valid", {31'b0, out_valid}, 32'd1);
`else
      chk("raw nobypass out_valid", {31'b0, out_valid}, 32'd0);
`endif
      tick();
      wb_done = 1'b0;
      #1;
      chk("raw cleared out_valid", {31'b0, out_valid}, 32'd1);

      // Back-pressure: outputs hold and a competing in_valid is ignored.
      in_valid = 1'b1;
      command  = 32'h34248001;
      pc       = 32'h200;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("bp%0d out_pc", i), out_pc, 32'h104);
         chk($sformatf("bp%0d wb_addr", i), {27'b0, wb_addr}, 32'd3);
         chk($sformatf("bp%0d stall", i), {31'b0, stall}, 32'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp not captured", {31'b0, out_valid}, 32'd0);
      retire(5'd3);

      // Flush coincident with fire and in_valid.
      load(32'h0C000010, 32'h300);
      chk("jal held", {31'b0, out_valid}, 32'd1);
      out_ready = 1'b1;
      flush     = 1'b1;
      in_valid  = 1'b1;
      command   = 32'h0;
      tick();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      chk("flush out_valid", {31'b0, out_valid}, 32'd0);
      chk("flush stall", {31'b0, stall}, 32'd0);
      load(32'h0C000010, 32'h304);
      chk("flush no pending r31", {31'b0, out_valid}, 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;

      // LW r5 fires in the same cycle r5 retires: the set wins.
      load(32'h8C65FFF0, 32'h400);
      out_ready    = 1'b1;
      wb_done      = 1'b1;
      wb_done_addr = 5'd5;
      tick();
      out_ready = 1'b0;
      wb_done   = 1'b0;
      load(32'h00A01821, 32'h404);
      tick();
      chk("setwins out_valid", {31'b0, out_valid}, 32'd0);

      // Reset while holding a blocked instruction clears it and the scoreboard.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst out_valid", {31'b0, out_valid}, 32'd0);
      chk("midrst stall", {31'b0, stall}, 32'd0);
      chk("midrst out_pc", out_pc, 32'd0);
      load(32'h00A01821, 32'h500);
      chk("midrst pending clear", {31'b0, out_valid}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
